// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and key classification helper for the
// keypad code lock.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_e;

    // True for the decimal digit keys 0-9.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Turns a bouncy key_valid/key pair into one key_event strobe per press.
// A press is accepted after DEBOUNCE_CYCLES stable pressed cycles, and the
// key must then be released for DEBOUNCE_CYCLES cycles before re-arming.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic       key_event,
    output logic [3:0] key_code
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            RELEASED = 1'b0;
    localparam logic            HELD     = 1'b1;

    logic          state_r;
    logic          state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [3:0]    cand_r;
    logic [3:0]    cand_nxt_s;
    logic          event_r;
    logic          event_nxt_s;
    logic [3:0]    code_r;
    logic [3:0]    code_nxt_s;

    // Next-state logic: count stable pressed cycles, then stable released cycles.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cand_nxt_s  = cand_r;
        event_nxt_s = 1'b0;
        code_nxt_s  = code_r;
        case (state_r)
            RELEASED: begin
                if (!key_valid) begin
                    cnt_nxt_s = '0;
                end else if ((cnt_r != '0) && (key == cand_r)) begin
                    if (cnt_r == CNT_LAST) begin
                        event_nxt_s = 1'b1;
                        code_nxt_s  = cand_r;
                        state_nxt_s = HELD;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    // first pressed cycle, or the code changed mid-press
                    cand_nxt_s = key;
                    cnt_nxt_s  = {{(CW-1){1'b0}}, 1'b1};
                end
            end
            HELD: begin
                if (key_valid) begin
                    cnt_nxt_s = '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = RELEASED;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RELEASED;
            cnt_r   <= '0;
            cand_r  <= 4'd0;
            event_r <= 1'b0;
            code_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cand_r  <= cand_nxt_s;
            event_r <= event_nxt_s;
            code_r  <= code_nxt_s;
        end
    end

    assign key_event = event_r;
    assign key_code  = code_r;

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: collects debounced digits, checks them against SECRET on
// '#', and drives unlock, failure and lockout status. All status outputs are
// registered copies of the next FSM state so they line up with the state.
module keypad_code_lock
    import keypad_pkg::*;
#(
    parameter int                    CODE_LEN        = 4,
    parameter logic [4*CODE_LEN-1:0] SECRET          = 16'h1234,
    parameter int                    DEBOUNCE_CYCLES = 16,
    parameter int                    UNLOCK_CYCLES   = 4096,
    parameter int                    LOCK_ATTEMPTS   = 3,
    parameter int                    LOCKOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic       key_event,
    output logic [3:0] last_key,
    output logic [2:0] digit_count,
    output logic       unlocked,
    output logic       fail_pulse,
    output logic       locked_out
);

    localparam int             BUF_W       = 4 * CODE_LEN;
    localparam int             TMAX        = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int             TW          = $clog2(TMAX) + 1;
    localparam int             AW          = $clog2(LOCK_ATTEMPTS) + 1;
    localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [AW-1:0]  ATT_LIMIT   = AW'(LOCK_ATTEMPTS);
    localparam logic [2:0]     LEN_V       = 3'(CODE_LEN);

    lock_state_e      state_r,  state_nxt_s;
    logic [BUF_W-1:0] buf_r,    buf_nxt_s;
    logic [2:0]       count_r,  count_nxt_s;
    logic             ovf_r,    ovf_nxt_s;
    logic [AW-1:0]    att_r,    att_nxt_s;
    logic [TW-1:0]    timer_r,  timer_nxt_s;
    logic             unlocked_r, fail_r, locked_r;
    logic             match_s;

    keypad_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_valid (key_valid),
        .key_event (key_event),
        .key_code  (last_key)
    );

    assign match_s = (count_r == LEN_V) && !ovf_r && (buf_r == SECRET);

    // FSM next-state, entry buffer, attempt counter and shared timer.
    always_comb begin
        state_nxt_s = state_r;
        buf_nxt_s   = buf_r;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        att_nxt_s   = att_r;
        timer_nxt_s = timer_r;
        case (state_r)
            ENTRY: begin
                if (key_event) begin
                    if (is_digit(last_key)) begin
                        if (count_r < LEN_V) begin
                            buf_nxt_s   = (buf_r << 4) | BUF_W'(last_key);
                            count_nxt_s = count_r + 1'b1;
                        end else begin
                            ovf_nxt_s = 1'b1;
                        end
                    end else if (last_key == KEY_STAR) begin
                        buf_nxt_s   = '0;
                        count_nxt_s = 3'd0;
                        ovf_nxt_s   = 1'b0;
                    end else if (last_key == KEY_HASH) begin
                        state_nxt_s = CHECK;
                    end else begin
                        // A-D carry no meaning here
                        state_nxt_s = ENTRY;
                    end
                end else begin
                    state_nxt_s = ENTRY;
                end
            end
            CHECK: begin
                buf_nxt_s   = '0;
                count_nxt_s = 3'd0;
                ovf_nxt_s   = 1'b0;
                timer_nxt_s = '0;
                if (match_s) begin
                    state_nxt_s = OPEN;
                    att_nxt_s   = '0;
                end else begin
                    state_nxt_s = FAIL;
                end
            end
            OPEN: begin
                if ((key_event && (last_key == KEY_STAR)) || (timer_r == UNLOCK_LAST)) begin
                    state_nxt_s = ENTRY;
                    timer_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + 1'b1;
                end
            end
            FAIL: begin
                att_nxt_s   = att_r + 1'b1;
                timer_nxt_s = '0;
                if ((att_r + 1'b1) == ATT_LIMIT) begin
                    state_nxt_s = LOCKOUT;
                end else begin
                    state_nxt_s = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer_r == LOCK_LAST) begin
                    state_nxt_s = ENTRY;
                    att_nxt_s   = '0;
                    timer_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = ENTRY;
                buf_nxt_s   = '0;
                count_nxt_s = 3'd0;
                ovf_nxt_s   = 1'b0;
                att_nxt_s   = '0;
                timer_nxt_s = '0;
            end
        endcase
    end

    // State registers; status outputs follow the next state so they are valid
    // from the first cycle of OPEN, FAIL and LOCKOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ENTRY;
            buf_r      <= '0;
            count_r    <= 3'd0;
            ovf_r      <= 1'b0;
            att_r      <= '0;
            timer_r    <= '0;
            unlocked_r <= 1'b0;
            fail_r     <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            buf_r      <= buf_nxt_s;
            count_r    <= count_nxt_s;
            ovf_r      <= ovf_nxt_s;
            att_r      <= att_nxt_s;
            timer_r    <= timer_nxt_s;
            unlocked_r <= (state_nxt_s == OPEN);
            fail_r     <= (state_nxt_s == FAIL);
            locked_r   <= (state_nxt_s == LOCKOUT);
        end
    end

    assign digit_count = count_r;
    assign unlocked    = unlocked_r;
    assign fail_pulse  = fail_r;
    assign locked_out  = locked_r;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock: a table of keystrokes with expected
// buffer/status after each, plus hand sequences for timing corner cases.
module tb_keypad_code_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       key_valid;
    logic       key_event;
    logic [3:0] last_key;
    logic [2:0] digit_count;
    logic       unlocked;
    logic       fail_pulse;
    logic       locked_out;

    int n_applied = 0;
    int n_err     = 0;
    int cyc       = 0;

    // event log maintained by the monitor
    int   ev_total   = 0;
    int   ev_cyc     = 0;
    int   fail_total = 0;
    int   fail_cyc   = 0;
    int   unl_rise   = 0;
    int   unl_fall   = 0;
    int   lck_rise   = 0;
    int   lck_fall   = 0;
    logic unl_prev   = 1'b0;
    logic lck_prev   = 1'b0;

    typedef struct {
        logic [3:0] k;
        logic [2:0] count;
        logic       unl;
        logic       lck;
        int         fails;
    } vec_t;

    vec_t vecs[31];

    keypad_code_lock #(
        .CODE_LEN        (4),
        .SECRET          (16'h1234),
        .DEBOUNCE_CYCLES (4),
        .UNLOCK_CYCLES   (20),
        .LOCK_ATTEMPTS   (3),
        .LOCKOUT_CYCLES  (30)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_valid   (key_valid),
        .key_event   (key_event),
        .last_key    (last_key),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .fail_pulse  (fail_pulse),
        .locked_out  (locked_out)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // cycle index = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // monitor on the falling edge: counts strobes and records edge times
    always @(negedge clk) begin
        if (key_event === 1'b1) begin
            ev_total <= ev_total + 1;
            ev_cyc   <= cyc;
        end
        if (fail_pulse === 1'b1) begin
            fail_total <= fail_total + 1;
            fail_cyc   <= cyc;
        end
        if (unlocked === 1'b1 && !unl_prev) unl_rise <= cyc;
        if (unlocked === 1'b0 && unl_prev)  unl_fall <= cyc;
        if (locked_out === 1'b1 && !lck_prev) lck_rise <= cyc;
        if (locked_out === 1'b0 && lck_prev)  lck_fall <= cyc;
        unl_prev <= (unlocked === 1'b1);
        lck_prev <= (locked_out === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clean press: 6 cycles held, 6 cycles released
    task automatic press(input logic [3:0] k);
        key       = k;
        key_valid = 1'b1;
        tick(6);
        key_valid = 1'b0;
        tick(6);
    endtask

    task automatic apply(input int lo, input int hi);
        int ev0;
        for (int i = lo; i <= hi; i++) begin
            ev0 = ev_total;
            press(vecs[i].k);
            check($sformatf("v%0d events", i), ev_total - ev0, 1);
            check($sformatf("v%0d last_key", i), last_key, vecs[i].k);
            check($sformatf("v%0d digit_count", i), digit_count, vecs[i].count);
            check($sformatf("v%0d unlocked", i), unlocked, vecs[i].unl);
            check($sformatf("v%0d locked_out", i), locked_out, vecs[i].lck);
            check($sformatf("v%0d fail_total", i), fail_total, vecs[i].fails);
        end
    endtask

    initial begin
        int ev0;
        //           key    count  unl   lck   fails
        vecs[0]  = '{4'd14, 3'd0, 1'b0, 1'b0, 0};  // clear the bounce digit
        vecs[1]  = '{4'd1,  3'd1, 1'b0, 1'b0, 0};  // correct code
        vecs[2]  = '{4'd2,  3'd2, 1'b0, 1'b0, 0};
        vecs[3]  = '{4'd3,  3'd3, 1'b0, 1'b0, 0};
        vecs[4]  = '{4'd4,  3'd4, 1'b0, 1'b0, 0};
        vecs[5]  = '{4'd15, 3'd0, 1'b1, 1'b0, 0};
        vecs[6]  = '{4'd1,  3'd1, 1'b0, 1'b0, 0};  // correct code again
        vecs[7]  = '{4'd2,  3'd2, 1'b0, 1'b0, 0};
        vecs[8]  = '{4'd3,  3'd3, 1'b0, 1'b0, 0};
        vecs[9]  = '{4'd4,  3'd4, 1'b0, 1'b0, 0};
        vecs[10] = '{4'd15, 3'd0, 1'b1, 1'b0, 0};
        vecs[11] = '{4'd14, 3'd0, 1'b0, 1'b0, 0};  // early relock
        vecs[12] = '{4'd1,  3'd1, 1'b0, 1'b0, 0};  // overflow entry
        vecs[13] = '{4'd2,  3'd2, 1'b0, 1'b0, 0};
        vecs[14] = '{4'd3,  3'd3, 1'b0, 1'b0, 0};
        vecs[15] = '{4'd4,  3'd4, 1'b0, 1'b0, 0};
        vecs[16] = '{4'd5,  3'd4, 1'b0, 1'b0, 0};
        vecs[17] = '{4'd15, 3'd0, 1'b0, 1'b0, 1};
        vecs[18] = '{4'd1,  3'd1, 1'b0, 1'b0, 1};  // short entry with an 'A'
        vecs[19] = '{4'd2,  3'd2, 1'b0, 1'b0, 1};
        vecs[20] = '{4'd10, 3'd2, 1'b0, 1'b0, 1};
        vecs[21] = '{4'd3,  3'd3, 1'b0, 1'b0, 1};
        vecs[22] = '{4'd15, 3'd0, 1'b0, 1'b0, 2};
        vecs[23] = '{4'd15, 3'd0, 1'b0, 1'b1, 3};  // empty entry -> third failure
        vecs[24] = '{4'd1,  3'd0, 1'b0, 1'b1, 3};  // ignored during lockout
        vecs[25] = '{4'd1,  3'd1, 1'b0, 1'b0, 3};  // correct code after lockout
        vecs[26] = '{4'd2,  3'd2, 1'b0, 1'b0, 3};
        vecs[27] = '{4'd3,  3'd3, 1'b0, 1'b0, 3};
        vecs[28] = '{4'd4,  3'd4, 1'b0, 1'b0, 3};
        vecs[29] = '{4'd15, 3'd0, 1'b1, 1'b0, 3};
        vecs[30] = '{4'd1,  3'd1, 1'b0, 1'b0, 3};  // entry works after reset

        // reset state
        rst       = 1'b1;
        key       = 4'd0;
        key_valid = 1'b0;
        tick(3);
        check("rst key_event",   key_event,   1'b0);
        check("rst last_key",    last_key,    4'd0);
        check("rst digit_count", digit_count, 3'd0);
        check("rst unlocked",    unlocked,    1'b0);
        check("rst fail_pulse",  fail_pulse,  1'b0);
        check("rst locked_out",  locked_out,  1'b0);
        rst = 1'b0;
        tick(2);

        // bounce: 3 high, 1 low, then held 110 cycles -> one event
        ev0       = ev_total;
        key       = 4'd5;
        key_valid = 1'b1;
        tick(3);
        key_valid = 1'b0;
        tick(1);
        key_valid = 1'b1;
        tick(110);
        key_valid = 1'b0;
        tick(6);
        check("bounce events",      ev_total - ev0, 1);
        check("bounce last_key",    last_key,       4'd5);
        check("bounce digit_count", digit_count,    3'd1);

        apply(0, 0);

        // correct code: unlock 2 cycles after '#', held for 20 cycles
        apply(1, 5);
        check("unlock latency", unl_rise - ev_cyc, 2);
        tick(20);
        check("unlock length", unl_fall - unl_rise, 20);
        check("unlock expired", unlocked, 1'b0);

        // early relock with '*' while open
        apply(6, 11);
        check("relock timing", unl_fall - ev_cyc, 1);

        // overflow then short entry
        apply(12, 17);
        check("fail latency", fail_cyc - ev_cyc, 2);
        apply(18, 22);

        // third failure -> lockout for 30 cycles, key ignored meanwhile
        apply(23, 24);
        tick(15);
        check("lockout length", lck_fall - lck_rise, 30);
        check("lockout over",   locked_out, 1'b0);

        // unlock again, then reset in the middle of OPEN
        apply(25, 29);
        rst = 1'b1;
        tick(1);
        check("mid-open rst unlocked",    unlocked,    1'b0);
        check("mid-open rst digit_count", digit_count, 3'd0);
        check("mid-open rst locked_out",  locked_out,  1'b0);
        rst = 1'b0;
        tick(1);
        apply(30, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

endmodule
